opregister_ctrl: RTL

Command sequencer for the 4-bit operation register (`opregister`). It accepts a load-and-evaluate command over a valid/ready handshake, then drives the register's `we`/`oe`/`opsel` pins in the required order. For each operation selected in the command mask it samples the register output and returns one result over a second valid/ready handshake. It sits between a command source (CPU glue or test driver) and one `opregister` instance, and never touches the register's own reset.

---
 rtl/opregister_ctrl_pkg.sv | 18 +
 rtl/opregister_ctrl_next_op.sv | 33 +++
 rtl/opregister_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/opregister_ctrl_pkg.sv
// Shared definitions for the opregister command sequencer.
//   state_t  : sequencer FSM states
//   OPSEL_W  : width of the register operation select
//   MASK_W   : one mask bit per selectable operation
package opregister_ctrl_pkg;

  localparam int OPSEL_W = 2;
  localparam int MASK_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SELECT,
    ENABLE,
    RESULT
  } state_t;

endpackage

// File: rtl/opregister_ctrl_next_op.sv
// Combinational scan for the next operation to run.
//   mask      : operations requested by the command
//   start_idx : lowest index that may be returned
//   next_idx  : lowest set mask bit at or above start_idx
//   last      : no mask bit above next_idx is set
// When no bit at or above start_idx is set, next_idx is 0; callers only
// consult it when a further operation is known to exist.
module opregister_ctrl_next_op
  import opregister_ctrl_pkg::*;
(
  input  logic [MASK_W-1:0]  mask,
  input  logic [OPSEL_W-1:0] start_idx,
  output logic [OPSEL_W-1:0] next_idx,
  output logic               last
);

  always_comb begin
    next_idx = '0;
    // Descending walk so the lowest qualifying bit is written last and wins.
    for (int j = MASK_W - 1; j >= 0; j--) begin
      if (mask[j] && (j >= int'(start_idx))) begin
        next_idx = OPSEL_W'(j);
      end
    end
    last = 1'b1;
    for (int j = 0; j < MASK_W; j++) begin
      if (mask[j] && (j > int'(next_idx))) begin
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/opregister_ctrl.sv
// Command sequencer for the 4-bit operation register.
// Accepts {data, mask} over a valid/ready handshake, pulses the register
// write enable once with the data, then for every set mask bit (ascending)
// selects the operation, holds oe for SETTLE_CYCLES, samples the register
// output and offers it as a result over a second valid/ready handshake.
// Ports:
//   i_w_clk, i_w_reset            : clock, synchronous active-high reset
//   i_w_cmd_* / o_w_cmd_ready     : command handshake (data, op mask)
//   o_w_res_* / i_w_res_ready     : result handshake (data, opsel, last)
//   o_w_reg_* / i_w_reg_out       : pins of the attached opregister
//   o_w_busy                      : high whenever the FSM is not idle
module opregister_ctrl
  import opregister_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_reset,
  input  logic                  i_w_cmd_valid,
  output logic                  o_w_cmd_ready,
  input  logic [DATA_WIDTH-1:0] i_w_cmd_data,
  input  logic [MASK_W-1:0]     i_w_cmd_mask,
  output logic                  o_w_res_valid,
  input  logic                  i_w_res_ready,
  output logic [DATA_WIDTH-1:0] o_w_res_data,
  output logic [OPSEL_W-1:0]    o_w_res_opsel,
  output logic                  o_w_res_last,
  output logic [DATA_WIDTH-1:0] o_w_reg_data,
  output logic                  o_w_reg_we,
  output logic                  o_w_reg_oe,
  output logic [OPSEL_W-1:0]    o_w_reg_opsel,
  input  logic [DATA_WIDTH-1:0] i_w_reg_out,
  output logic                  o_w_busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t               state;
  logic [MASK_W-1:0]    mask_q;
  logic                 last_q;
  logic [CNT_W-1:0]     settle_cnt;

  logic [MASK_W-1:0]    scan_mask;
  logic [OPSEL_W-1:0]   scan_start;
  logic [OPSEL_W-1:0]   scan_idx;
  logic                 scan_last;

  // The scanner serves both the command handshake (live mask, from bit 0)
  // and result handshakes (latched mask, from the bit above the current op).
  always_comb begin
    scan_mask  = mask_q;
    scan_start = o_w_reg_opsel + OPSEL_W'(1);
    if (state == IDLE) begin
      scan_mask  = i_w_cmd_mask;
      scan_start = '0;
    end
  end

  opregister_ctrl_next_op u_next_op (
    .mask      (scan_mask),
    .start_idx (scan_start),
    .next_idx  (scan_idx),
    .last      (scan_last)
  );

  // Gated by reset so ready is low while reset is held and high in the
  // very first cycle after release.
  assign o_w_cmd_ready = (state == IDLE) && !i_w_reset;

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state         <= IDLE;
      mask_q        <= '0;
      last_q        <= 1'b0;
      settle_cnt    <= '0;
      o_w_reg_data  <= '0;
      o_w_reg_we    <= 1'b0;
      o_w_reg_oe    <= 1'b0;
      o_w_reg_opsel <= '0;
      o_w_res_valid <= 1'b0;
      o_w_res_data  <= '0;
      o_w_res_opsel <= '0;
      o_w_res_last  <= 1'b0;
      o_w_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_w_cmd_valid) begin
            o_w_reg_data  <= i_w_cmd_data;
            mask_q        <= i_w_cmd_mask;
            o_w_reg_opsel <= scan_idx;
            last_q        <= scan_last;
            o_w_reg_we    <= 1'b1;
            o_w_busy      <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          o_w_reg_we <= 1'b0;
          if (mask_q != '0) begin
            state <= SELECT;
          end else begin
            o_w_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        SELECT: begin
          o_w_reg_oe <= 1'b1;
          settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
          state      <= ENABLE;
        end
        ENABLE: begin
          if (settle_cnt == '0) begin
            o_w_reg_oe    <= 1'b0;
            o_w_res_valid <= 1'b1;
            o_w_res_data  <= i_w_reg_out;
            o_w_res_opsel <= o_w_reg_opsel;
            o_w_res_last  <= last_q;
            state         <= RESULT;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        RESULT: begin
          if (i_w_res_ready) begin
            o_w_res_valid <= 1'b0;
            if (o_w_res_last) begin
              o_w_busy <= 1'b0;
              state    <= IDLE;
            end else begin
              // opsel only moves here, while oe is already low.
              o_w_reg_opsel <= scan_idx;
              last_q        <= scan_last;
              state         <= SELECT;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
